// File: rtl/adc_filter_pkg.sv
// adc_filter_pkg: shared defaults and FSM encoding for the ADC sample filter
package adc_filter_pkg;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_LOG2_TAPS = 3;
  localparam int DEF_HI_THRESH = 3000;
  localparam int DEF_LO_THRESH = 2800;
  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/sample_ring.sv
// sample_ring: TAPS-entry sample ring; rd_data is the oldest entry, the one the next write replaces
module sample_ring #(
  parameter int DATA_W = 12,
  parameter int LOG2_TAPS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              we,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
  localparam int TAPS = 1 << LOG2_TAPS;
  logic [DATA_W-1:0] mem [TAPS];
  logic [LOG2_TAPS-1:0] wr_ptr;
  assign rd_data = mem[wr_ptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr <= wr_ptr + LOG2_TAPS'(1);
    end
endmodule

// File: rtl/adc_sample_filter.sv
// adc_sample_filter: moving-average ADC filter with hysteretic alarm and peak hold
module adc_sample_filter
  import adc_filter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LOG2_TAPS = DEF_LOG2_TAPS,
  parameter int HI_THRESH = DEF_HI_THRESH,
  parameter int LO_THRESH = DEF_LO_THRESH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_avg,
  output logic              warm,
  output logic              alarm,
  output logic [DATA_W-1:0] peak
);
  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int SW = DATA_W + LOG2_TAPS;
  localparam logic [DATA_W-1:0] HI = DATA_W'(HI_THRESH);
  localparam logic [DATA_W-1:0] LO = DATA_W'(LO_THRESH);
  state_t state;
  logic [LOG2_TAPS-1:0] count;
  logic [SW-1:0] sum, sum_next;
  logic [DATA_W-1:0] oldest, avg_next;
  logic accept, last, load;
  assign in_ready = ~clear & (~out_valid | out_ready);
  assign accept = in_valid & in_ready;
  assign last = count == LOG2_TAPS'(TAPS - 1);
  assign load = accept & (state == RUN | last);
  assign sum_next = sum + SW'(in_data) - SW'(oldest);
  assign avg_next = sum_next[SW-1:LOG2_TAPS];
  assign warm = state == RUN;
  sample_ring #(.DATA_W(DATA_W), .LOG2_TAPS(LOG2_TAPS)) u_ring (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .we(accept),
    .wr_data(in_data),
    .rd_data(oldest)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= FILL;
      count <= '0;
      sum <= '0;
      out_valid <= 1'b0;
      out_avg <= '0;
      alarm <= 1'b0;
      peak <= '0;
    end else if (clear) begin
      state <= FILL;
      count <= '0;
      sum <= '0;
      out_valid <= 1'b0;
      alarm <= 1'b0;
      peak <= '0;
    end else begin
      if (accept) begin
        sum <= sum_next;
        if (state == FILL) begin
          count <= count + LOG2_TAPS'(1);
          if (last) state <= RUN;
        end
      end
      if (load) begin
        out_avg <= avg_next;
        out_valid <= 1'b1;
        alarm <= avg_next >= HI ? 1'b1 : avg_next <= LO ? 1'b0 : alarm;
        if (avg_next > peak) peak <= avg_next;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_adc_sample_filter.sv
// tb_adc_sample_filter: directed vector table, corner sequences and a random run against a window model
module tb_adc_sample_filter;
  logic clk = 0, reset = 1, clear = 0, in_valid = 0, out_ready = 1;
  logic [11:0] in_data = 0;
  logic in_ready, out_valid, warm, alarm;
  logic [11:0] out_avg, peak;
  logic rdy_seen;
  int passed = 0, total = 0;
  typedef struct {
    logic c, v;
    logic [11:0] d;
    logic ev, ew, ea;
    int eavg;
  } vec_t;
  vec_t tbl[$];
  adc_sample_filter dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_avg(out_avg),
    .warm(warm), .alarm(alarm), .peak(peak)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    else passed++;
  endtask
  task automatic cyc(input logic c, input logic v, input logic [11:0] d, input logic r);
    @(negedge clk);
    clear = c; in_valid = v; in_data = d; out_ready = r;
    #1 rdy_seen = in_ready;
    @(posedge clk);
    #1;
  endtask
  function automatic void add(input logic c, input logic v, input int d, input logic ev,
                              input logic ew, input logic ea, input int eavg);
    vec_t t;
    t.c = c; t.v = v; t.d = 12'(d); t.ev = ev; t.ew = ew; t.ea = ea; t.eavg = eavg;
    tbl.push_back(t);
  endfunction
  int win[8];
  int n, mavg, mpeak, s;
  bit mv, ma, c, v, r, er;
  int d;
  initial begin
    for (int i = 0; i < 8; i++) add(0, 1, 100, i == 7, i == 7, 0, 100);
    add(1, 1, 999, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) add(0, 1, 8 * i, i == 8, i == 8, 0, 36);
    add(0, 1, 72, 1, 1, 0, 44);
    add(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 100, i == 7, i == 7, 0, 100);
    for (int k = 1; k <= 8; k++) add(0, 1, 4000, 1, 1, k >= 6, (k * 4000 + (8 - k) * 100) / 8);
    add(0, 1, 0, 1, 1, 1, 3500);
    add(0, 1, 0, 1, 1, 1, 3000);
    add(0, 1, 0, 1, 1, 0, 2500);
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_avg", out_avg, 0);
    chk("reset warm", warm, 0);
    chk("reset alarm", alarm, 0);
    chk("reset peak", peak, 0);
    @(negedge clk) reset = 0;
    foreach (tbl[i]) begin
      cyc(tbl[i].c, tbl[i].v, tbl[i].d, 1'b1);
      chk($sformatf("vec%0d in_ready", i), rdy_seen, !tbl[i].c);
      chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("vec%0d warm", i), warm, tbl[i].ew);
      chk($sformatf("vec%0d alarm", i), alarm, tbl[i].ea);
      if (tbl[i].ev) chk($sformatf("vec%0d out_avg", i), out_avg, tbl[i].eavg);
    end
    chk("peak after hysteresis", peak, 4000);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 50, 0);
      chk("stall in_ready", rdy_seen, 0);
      chk("stall out_valid", out_valid, 1);
      chk("stall out_avg", out_avg, 2500);
    end
    cyc(0, 1, 50, 1);
    chk("release in_ready", rdy_seen, 1);
    chk("release out_valid", out_valid, 1);
    chk("release out_avg", out_avg, 2006);
    cyc(1, 1, 4000, 1);
    chk("clear in_ready", rdy_seen, 0);
    chk("clear warm", warm, 0);
    chk("clear peak", peak, 0);
    chk("clear out_valid", out_valid, 0);
    chk("clear alarm", alarm, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 3500, 1);
      chk("refill no output", out_valid, 0);
    end
    cyc(0, 1, 3500, 0);
    chk("refill out_valid", out_valid, 1);
    chk("refill out_avg", out_avg, 3500);
    chk("refill alarm", alarm, 1);
    chk("refill peak", peak, 3500);
    @(negedge clk);
    reset = 1; in_valid = 0;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset alarm", alarm, 0);
    chk("async reset peak", peak, 0);
    chk("async reset warm", warm, 0);
    @(negedge clk) reset = 0;
    n = 0; mv = 0; ma = 0; mavg = 0; mpeak = 0;
    for (int i = 0; i < 8; i++) win[i] = 0;
    for (int it = 0; it < 400; it++) begin
      c = $urandom_range(0, 39) == 0;
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 3) != 0;
      d = $urandom_range(1500, 4095);
      er = !c && (!mv || r);
      cyc(c, v, 12'(d), r);
      chk("rnd in_ready", rdy_seen, er);
      if (c) begin
        for (int i = 0; i < 8; i++) win[i] = 0;
        n = 0; mv = 0; ma = 0; mpeak = 0;
      end else if (v && er) begin
        for (int i = 7; i > 0; i--) win[i] = win[i-1];
        win[0] = d;
        if (n < 8) n++;
        if (n == 8) begin
          s = 0;
          foreach (win[i]) s += win[i];
          mavg = s / 8;
          mv = 1;
          if (mavg >= 3000) ma = 1;
          else if (mavg <= 2800) ma = 0;
          if (mavg > mpeak) mpeak = mavg;
        end else if (r) mv = 0;
      end else if (r) mv = 0;
      chk("rnd out_valid", out_valid, mv);
      chk("rnd warm", warm, n == 8);
      chk("rnd alarm", alarm, ma);
      chk("rnd peak", peak, mpeak);
      if (mv) chk("rnd out_avg", out_avg, mavg);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/adc_sample_filter.md
ADC_SAMPLE_FILTER -- requirements
Module: adc_sample_filter

Interface
REQ-001 SHALL have parameter DATA_W, default 12, ADC sample width.
REQ-002 SHALL have parameter LOG2_TAPS, default 3, log2 of moving-average window (TAPS = 8).
REQ-003 SHALL have parameter HI_THRESH, default 3000, alarm set level.
REQ-004 SHALL have parameter LO_THRESH, default 2800, alarm clear level; LO_THRESH < HI_THRESH.
REQ-005 SHALL have port clk  in  1  system clock.
REQ-006 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port clear  in  1  synchronous flush of window, alarm, peak.
REQ-008 SHALL have port in_valid  in  1  sample from ADC interface is valid.
REQ-009 SHALL have port in_data  in  DATA_W  raw ADC sample.
REQ-010 SHALL have port in_ready  out  1  block accepts sample this cycle.
REQ-011 SHALL have port out_valid  out  1  filtered average valid.
REQ-012 SHALL have port out_ready  in  1  consumer accepts average.
REQ-013 SHALL have port out_avg  out  DATA_W  moving average.
REQ-014 SHALL have port warm  out  1  window full, outputs being produced.
REQ-015 SHALL have port alarm  out  1  hysteretic over-threshold flag.
REQ-016 SHALL have port peak  out  DATA_W  largest out_avg since reset/clear.

Function
REQ-017 SHALL accept a sample when in_valid & in_ready; in_ready = ~clear & (~out_valid | out_ready).
REQ-018 SHALL store accepted sample at wr_ptr in a TAPS-entry ring, wr_ptr wraps TAPS-1 -> 0.
REQ-019 SHALL keep running sum of width DATA_W+LOG2_TAPS: sum_next = sum + in_data - ring[wr_ptr]; no overflow possible.
REQ-020 SHALL implement FSM FILL -> RUN: FILL counts accepted samples; on TAPS-th accept go RUN and set warm.
REQ-021 SHALL produce no output in FILL; in RUN (including the TAPS-th accept) each accept loads out_avg = sum_next >> LOG2_TAPS (truncate) and sets out_valid next cycle (latency 1).
REQ-022 SHALL hold out_avg stable and out_valid high until out_ready; accept + out_ready same cycle replaces output without bubble.
REQ-023 SHALL set alarm when a newly loaded out_avg >= HI_THRESH, clear when <= LO_THRESH, otherwise hold.
REQ-024 SHALL update peak when a newly loaded out_avg > peak.
REQ-025 SHALL on clear: return FILL, zero sum, ring, wr_ptr, count, warm, alarm, peak, out_valid; clear wins over simultaneous in_valid (sample dropped).

Reset
REQ-026 SHALL on reset: state FILL, out_valid 0, out_avg 0, warm 0, alarm 0, peak 0, sum 0, wr_ptr 0, count 0, all ring entries 0.
REQ-027 SHALL abort any pending output immediately on reset mid-operation; first output after release needs TAPS fresh samples.

Structure
REQ-028 SHALL place DATA_W, LOG2_TAPS, threshold defaults and FSM state encodings in shared package adc_filter_pkg.
REQ-029 SHALL instantiate one sub-module sample_ring (TAPS x DATA_W register ring, write port, read-at-pointer, sync clear).

Verification
REQ-030 SHALL cover fill: eight samples of 100 -> no out_valid for first seven; out_avg=100, warm=1 one cycle after eighth.
REQ-031 SHALL cover wrap: samples 8,16,...,72 -> out_avg 36 after ninth-but-one (8..64), 44 after ninth.
REQ-032 SHALL cover hysteresis: warm at 100, then 4000s -> alarm sets on sixth (avg 3025), not fifth (2537); then all-4000 window, 0s -> alarm clears on third 0 (2500), held at 3000.
REQ-033 SHALL cover backpressure: out_ready=0, in_valid=1 -> in_ready=0, out_avg unchanged for 10 cycles; out_ready=1 -> next sample accepted same cycle.
REQ-034 SHALL cover clear with simultaneous in_valid -> sample dropped, warm=0, peak=0, next seven accepts produce no output.
REQ-035 SHALL cover reset asserted while out_valid=1 -> out_valid, alarm, peak 0 asynchronously.
